// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Packs symbolic instruction fields (op, ra, rb, mode, imm) into 9-bit
//   machine words and streams them into instruction memory at consecutive
//   addresses. Beats whose fields the decoder cannot execute are dropped;
//   the first one of a session is flagged in err/err_addr.
//
// Parameters:
//   PW     instruction address width
//   DEPTH  instruction memory words (must be <= 2**PW)
//
// Ports:
//   clk, reset_n          rising-edge clock, async active-low reset
//   start, base_addr      open a session at base_addr (only from IDLE/FULL)
//   in_valid, in_ready    field-beat handshake
//   last                  beat closes the session
//   op, ra, rb, mode, imm symbolic instruction fields
//   wr_en/wr_addr/wr_data registered instruction-memory write port
//   busy, done, full      session active / end-of-session pulse / top reached
//   err, err_addr         sticky illegal-beat flag / address of first one
//   count                 words written this session
//
// Configuration macro:
//   ENC_CHECKSUM_EN  adds csum[8:0], XOR of every wr_data of the session.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no session; waiting for start
// LOAD  | session open; accepting beats
// FULL  | memory top written; waiting for start
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int PW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [PW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          last,
    input  logic [2:0]    op,
    input  logic [2:0]    ra,
    input  logic [2:0]    rb,
    input  logic [3:0]    mode,
    input  logic [3:0]    imm,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [8:0]    wr_data,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err,
    output logic [PW-1:0] err_addr,
    output logic [PW:0]   count
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [8:0]    csum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr;
    logic [5:0]    enc_low;
    logic [8:0]    enc;
    logic          legal;
    logic          load_st;
    logic          accept;
    logic          start_ok;
    logic          at_top;

    assign load_st  = (state == LOAD);
    assign accept   = in_valid && load_st;
    assign start_ok = start && (state == IDLE || state == FULL);
    assign at_top   = (ptr == PW'(DEPTH - 1));
    assign enc      = {op, enc_low};

    // Field packing and legality check, one entry per op class.
    always_comb begin
        enc_low = 6'b0;
        legal   = 1'b1;
        case (op)
            3'b000, 3'b001, 3'b010: enc_low = {ra, rb};
            3'b011: begin
                enc_low = {ra[1:0], mode[3], rb};
                legal   = ~ra[2];
            end
            3'b100: begin
                enc_low = {ra[1:0], imm};
                legal   = ra[2];
            end
            3'b101: begin
                enc_low = {ra, mode[2:0]};
                legal   = (mode[2:0] == 3'b000) || (mode[2:0] == 3'b010) ||
                          (mode[2:0] == 3'b011) || (mode[2:0] == 3'b100) ||
                          (mode[2:0] == 3'b110);
            end
            3'b110:  enc_low = {ra, mode[2:0]};
            default: enc_low = {2'b00, mode};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (last)                 state_nxt = IDLE;
                    else if (legal && at_top) state_nxt = FULL;
                end
            end
            FULL: if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            count    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
`ifdef ENC_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (start_ok) begin
                ptr      <= base_addr;
                count    <= '0;
                err      <= 1'b0;
                err_addr <= '0;
                full     <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (accept) begin
                if (legal) begin
                    wr_en   <= 1'b1;
                    wr_addr <= ptr;
                    wr_data <= enc;
                    count   <= count + (PW+1)'(1);
`ifdef ENC_CHECKSUM_EN
                    csum    <= csum ^ enc;
`endif
                    // Pointer parks at the top word instead of wrapping.
                    if (at_top) full <= 1'b1;
                    else        ptr  <= ptr + PW'(1);
                end else if (!err) begin
                    err      <= 1'b1;
                    err_addr <= ptr;
                end
                // Aligned with the write slot of the closing beat.
                if (last || (legal && at_top)) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int PW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [PW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic          last;
    logic [2:0]    op, ra, rb;
    logic [3:0]    mode, imm;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic          busy, done, full, err;
    logic [PW-1:0] err_addr;
    logic [PW:0]   count;
`ifdef ENC_CHECKSUM_EN
    logic [8:0]    csum;
`endif

    int checks = 0;
    int errors = 0;

    instr_encoder_loader #(.PW(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .last(last),
        .op(op), .ra(ra), .rb(rb), .mode(mode), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .full(full),
        .err(err), .err_addr(err_addr), .count(count)
`ifdef ENC_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] m, input logic [3:0] i, input logic l);
        op = o; ra = a; rb = b; mode = m; imm = i; last = l;
        in_valid = 1'b1;
        step();
    endtask

    task automatic open_session(input logic [PW-1:0] base);
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [PW-1:0] a, input logic [8:0] d);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, "_wr_data"}, 32'(wr_data), 32'(d));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_addr"}, 32'(err_addr), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; last = 1'b0;
        op = '0; ra = '0; rb = '0; mode = '0; imm = '0;
        step(); step();
        chk_zero("reset");
        reset_n = 1'b1;
        step();

        // Session 1: ADD then XOR with last, back to back.
        open_session(10'd0);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_in_ready", 32'(in_ready), 32'd1);
        send(3'b000, 3'd1, 3'd2, 4'd0, 4'd0, 1'b0);
        chk_wr("s1_add", 10'd0, 9'h00A);
        chk("s1_add_done", 32'(done), 32'd0);
        send(3'b001, 3'd3, 3'd4, 4'd0, 4'd0, 1'b1);
        chk_wr("s1_xor", 10'd1, 9'h05C);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_count", 32'(count), 32'd2);
        chk("s1_busy_end", 32'(busy), 32'd0);
        in_valid = 1'b0; last = 1'b0;
        step();
        chk("s1_done_pulse", 32'(done), 32'd0);
        chk("s1_wr_idle", 32'(wr_en), 32'd0);

        // Session 2: ADDI, ignored start mid-session, STO with last.
        open_session(10'h010);
        send(3'b100, 3'd5, 3'd0, 4'd0, 4'hF, 1'b0);
        chk_wr("s2_addi", 10'h010, 9'h11F);
        in_valid = 1'b0; start = 1'b1; base_addr = 10'h200;
        step();
        start = 1'b0;
        chk("s2_start_ignored_busy", 32'(busy), 32'd1);
        send(3'b011, 3'd2, 3'd6, 4'b1000, 4'd0, 1'b1);
        chk_wr("s2_sto", 10'h011, 9'h0EE);
        chk("s2_err", 32'(err), 32'd0);
        chk("s2_count", 32'(count), 32'd2);
        in_valid = 1'b0; last = 1'b0;
        step();

        // Session 3: illegal beats interleaved with legal ones.
        open_session(10'd7);
        send(3'b011, 3'd4, 3'd1, 4'd0, 4'd0, 1'b0);
        chk("s3_lod_wr_en", 32'(wr_en), 32'd0);
        chk("s3_lod_err", 32'(err), 32'd1);
        chk("s3_lod_err_addr", 32'(err_addr), 32'd7);
        chk("s3_lod_count", 32'(count), 32'd0);
        send(3'b000, 3'd1, 3'd2, 4'd0, 4'd0, 1'b0);
        chk_wr("s3_add", 10'd7, 9'h00A);
        chk("s3_add_count", 32'(count), 32'd1);
        send(3'b101, 3'd0, 3'd0, 4'b0001, 4'd0, 1'b0);
        chk("s3_shf001_wr_en", 32'(wr_en), 32'd0);
        send(3'b101, 3'd0, 3'd0, 4'b0111, 4'd0, 1'b0);
        chk("s3_shf111_wr_en", 32'(wr_en), 32'd0);
        chk("s3_err_addr_kept", 32'(err_addr), 32'd7);
        send(3'b101, 3'd2, 3'd0, 4'b0010, 4'd0, 1'b0);
        chk_wr("s3_shf010", 10'd8, 9'h152);
        send(3'b111, 3'd0, 3'd0, 4'b1011, 4'd0, 1'b0);
        chk_wr("s3_par", 10'd9, 9'h1CB);
        send(3'b110, 3'd3, 3'd0, 4'b0101, 4'd0, 1'b1);
        chk_wr("s3_br", 10'd10, 9'h19D);
        chk("s3_done", 32'(done), 32'd1);
        chk("s3_count", 32'(count), 32'd4);
        chk("s3_err_sticky", 32'(err), 32'd1);
        in_valid = 1'b0; last = 1'b0;
        step();

        // Session 4: run into the top of memory.
        open_session(10'(DEPTH - 2));
        chk("s4_err_cleared", 32'(err), 32'd0);
        send(3'b000, 3'd1, 3'd2, 4'd0, 4'd0, 1'b0);
        chk_wr("s4_w1022", 10'd1022, 9'h00A);
        chk("s4_full_early", 32'(full), 32'd0);
        send(3'b010, 3'd7, 3'd7, 4'd0, 4'd0, 1'b0);
        chk_wr("s4_w1023", 10'd1023, 9'h0BF);
        chk("s4_full", 32'(full), 32'd1);
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_in_ready", 32'(in_ready), 32'd0);
        send(3'b000, 3'd5, 3'd5, 4'd0, 4'd0, 1'b0);
        chk("s4_third_wr_en", 32'(wr_en), 32'd0);
        chk("s4_third_count", 32'(count), 32'd2);
        chk("s4_still_full", 32'(full), 32'd1);

        // Start and beat together from FULL: start wins.
        start = 1'b1; base_addr = 10'h040;
        op = 3'b000; ra = 3'd1; rb = 3'd2; last = 1'b0; in_valid = 1'b1;
        step();
        start = 1'b0;
        chk("s5_full_cleared", 32'(full), 32'd0);
        chk("s5_no_wr", 32'(wr_en), 32'd0);
        chk("s5_busy", 32'(busy), 32'd1);
        step();
        chk_wr("s5_add", 10'h040, 9'h00A);

        // Reset right after an accept drops the pending write.
        ra = 3'd3;
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        in_valid = 1'b0;
        chk_zero("s6_reset");
        step();
        reset_n = 1'b1;
        step();
        chk_zero("s6_after");
        open_session(10'h055);
        send(3'b000, 3'd1, 3'd2, 4'd0, 4'd0, 1'b0);
        chk_wr("s6_restart", 10'h055, 9'h00A);
        chk("s6_count", 32'(count), 32'd1);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
